lc3_mem_responder: RTL and testbench
====================================

Name: lc3_mem_responder

Overview:
- Clocked, wait-stated memory responder for the SimpleLC3 data/instruction bus; the target end of the CPU's addr/din/rd/dout/complete handshake.
- Models realistic multi-cycle memory latency so the CPU's stall-on-complete logic is exercised.
- Keeps the testbench instruction preload port (write_inst/addr_inst/din_inst).
- Drop-in alternative to the combinational memory in the top-level.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, bus address width.
- DEPTH, 256, number of words stored; power of two, at most 2**ADDR_W.
- LATENCY, 2, wait cycles between request capture and completion; 0 to 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_inst  in  1  preload strobe; writes din_inst to addr_inst on this clock edge.
- addr_inst  in  ADDR_W  preload address.
- din_inst  in  DATA_W  preload data.
- req  in  1  CPU request valid; sampled only in IDLE.
- rd  in  1  1 = read, 0 = write; sampled with req.
- addr  in  ADDR_W  CPU address.
- din  in  DATA_W  CPU write data.
- dout  out  DATA_W  read data; valid while complete=1.
- complete  out  1  one-cycle done pulse for the current transaction.
- busy  out  1  high from the cycle after request capture until complete.

Behaviour:
- Reset (reset=0, async): state=IDLE, complete=0, busy=0, dout=0, wait counter=0. Array contents are not cleared.
- FSM has three states.
  - IDLE: if req=1, latch addr, din and rd; go to WAIT with cnt=LATENCY. If LATENCY=0, go directly to ACCESS.
  - WAIT: cnt decrements each cycle; go to ACCESS when cnt reaches 1.
  - ACCESS: perform array access, complete=1 for exactly this cycle.
    - Read: dout=mem[addr_l].
    - Write: mem[addr_l]<=din_l; dout keeps its previous value.
    - Next state is IDLE.
- Latency: req sampled at edge N; complete is high during cycle N+LATENCY+1.
- busy=1 in WAIT and ACCESS.
- req is ignored while busy. Back-to-back requests are accepted at the earliest in the cycle after complete.
- Address mapping: index = addr[log2(DEPTH)-1:0]; upper bits ignored (wrap-around).
- Preload:
  - write_inst writes on any cycle, independent of the FSM.
  - Preload and ACCESS write to the same index on the same edge: preload wins.
  - Preload to the index being read in ACCESS: the read returns the old data (read-before-write).
- Reset asserted mid-transaction: the transaction is abandoned, no array write, complete is never pulsed.
- dout holds its last read value between transactions.

Optional Feature:
- Macro: LC3_MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - In ACCESS, if the latched addr >= DEPTH: err=1 together with complete, no array write, and dout=0 for reads.
  - err otherwise 0.
  - Out-of-range preload writes are dropped.
- Undefined: no err port; all addresses wrap as above.

Decomposition:
- Package lc3_mem_pkg:
  - State enum {IDLE, WAIT, ACCESS}.
  - Default width constants.
  - Counter width constant (4 bits).
- Sub-module lc3_mem_array: DEPTH x DATA_W register array with one CPU read/write port and one preload write port, with the preload-priority rule above.
- The FSM, latches and counter stay in lc3_mem_responder.

Test Plan:
- Read: preload 0x0010=0x1234; LATENCY=2; req, rd=1, addr=0x0010 at edge 0 → complete=1 and dout=0x1234 in cycle 3 only; busy=1 in cycles 1-3.
- Write then read: write 0xBEEF to 0x0020, then read 0x0020 → dout=0xBEEF. A req held high during busy must not start a second transaction.
- Wrap: DEPTH=256; write 0xAAAA to 0x0105, read 0x0005 → 0xAAAA. With LC3_MEM_RANGE_CHECK_EN: err=1, no write, and a read of 0x0005 is unchanged.
- Collision: ACCESS write 0x1111 to index 7 on the same edge as preload 0x2222 to index 7 → subsequent read returns 0x2222.
- Reset mid-WAIT: write request to 0x0030 (old value 0x5555), pull reset low in cycle 1 → complete never pulses, state=IDLE, mem[0x30]=0x5555.
- LATENCY=0: req at edge 0 → complete in cycle 1; requests on every other cycle each get one complete.

Source files
------------

// File: rtl/lc3_mem_responder_pkg.sv
// Shared types and default sizing for the LC3 wait-stated memory responder.
package lc3_mem_pkg;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF   = 256;
  localparam int unsigned LATENCY_DEF = 2;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;
endpackage

// File: rtl/lc3_mem_responder_if.sv
// CPU-side request/response bus between the SimpleLC3 core and its memory.
interface lc3_mem_responder_if
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              req;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              complete;
  logic              busy;

  modport master (output req, rd, addr, din, input dout, complete, busy);
  modport slave  (input req, rd, addr, din, output dout, complete, busy);
endinterface

// File: rtl/lc3_mem_responder_array.sv
// DEPTH x DATA_W storage with one CPU read/write port and one preload write port.
module lc3_mem_array
  import lc3_mem_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              cpu_we,
  input  logic [IDX_W-1:0]  cpu_idx,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              pre_we,
  input  logic [IDX_W-1:0]  pre_idx,
  input  logic [DATA_W-1:0] pre_wdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Combinational read sees pre-edge contents, so a same-edge preload is read-before-write.
  assign cpu_rdata = mem[cpu_idx];

  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_idx] <= cpu_wdata;
    // Preload assigned last so it wins a same-index collision.
    if (pre_we) mem[pre_idx] <= pre_wdata;
  end
endmodule

// File: rtl/lc3_mem_responder.sv
// Wait-stated memory responder for the SimpleLC3 bus with a testbench preload port.
// Optional LC3_MEM_RANGE_CHECK_EN adds err and rejects addresses >= DEPTH.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_inst,
  input  logic [ADDR_W-1:0] addr_inst,
  input  logic [DATA_W-1:0] din_inst,
  lc3_mem_responder_if.slave bus
`ifdef LC3_MEM_RANGE_CHECK_EN
  ,
  output logic              err
`endif
);
  localparam int unsigned      IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] din_l;
  logic              rd_l;
  logic [DATA_W-1:0] dout_q, rdata, dout_now;
  logic              access, cpu_we, pre_we;
  logic              addr_hi, inst_hi, oor, pre_oor;

  assign access  = (state == ACCESS);
  assign addr_hi = (addr_l >> IDX_W) != '0;
  assign inst_hi = (addr_inst >> IDX_W) != '0;

`ifdef LC3_MEM_RANGE_CHECK_EN
  assign oor     = addr_hi;
  assign pre_oor = inst_hi;
  assign err     = access && oor;
`else
  // Upper address bits are don't-care: addresses wrap onto the array.
  logic unused_hi;
  assign unused_hi = addr_hi ^ inst_hi;
  assign oor       = 1'b0;
  assign pre_oor   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = (LATENCY == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt <= CNT_W'(1)) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      addr_l <= '0;
      din_l  <= '0;
      rd_l   <= 1'b0;
      dout_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          addr_l <= bus.addr;
          din_l  <= bus.din;
          rd_l   <= bus.rd;
          cnt    <= LAT_CNT;
        end
        WAIT:    cnt <= cnt - CNT_W'(1);
        ACCESS:  if (rd_l) dout_q <= dout_now;
        default: ;
      endcase
    end
  end

  // dout is live from the array during ACCESS and held from dout_q otherwise.
  always_comb begin
    bus.complete = access;
    bus.busy     = (state != IDLE);
    cpu_we       = access && !rd_l && !oor;
    dout_now     = oor ? '0 : rdata;
    bus.dout     = (access && rd_l) ? dout_now : dout_q;
  end

  assign pre_we = write_inst && !pre_oor;

  lc3_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk       (clk),
    .cpu_we    (cpu_we),
    .cpu_idx   (addr_l[IDX_W-1:0]),
    .cpu_wdata (din_l),
    .cpu_rdata (rdata),
    .pre_we    (pre_we),
    .pre_idx   (addr_inst[IDX_W-1:0]),
    .pre_wdata (din_inst)
  );
endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench: LATENCY=2 and LATENCY=0 responders against a scoreboard model.
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  typedef struct {
    logic [15:0] data;
    bit          is_read;
    bit          oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_inst = 1'b0;
  logic [15:0] addr_inst = '0;
  logic [15:0] din_inst = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q2[$];
  exp_t        q0[$];
  logic [15:0] m2[256];
  logic [15:0] m0[256];
  logic [15:0] last2 = '0;
  logic [15:0] last0 = '0;

  lc3_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();
  lc3_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

`ifdef LC3_MEM_RANGE_CHECK_EN
  logic err2, err0;
`endif

  lc3_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .write_inst(write_inst), .addr_inst(addr_inst),
    .din_inst(din_inst), .bus(bus2)
`ifdef LC3_MEM_RANGE_CHECK_EN
    , .err(err2)
`endif
  );

  lc3_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .write_inst(write_inst), .addr_inst(addr_inst),
    .din_inst(din_inst), .bus(bus0)
`ifdef LC3_MEM_RANGE_CHECK_EN
    , .err(err0)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit is_oor(input logic [15:0] a);
`ifdef LC3_MEM_RANGE_CHECK_EN
    return a[15:8] != 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    write_inst = 1'b1; addr_inst = a; din_inst = d;
    if (!is_oor(a)) begin m2[a[7:0]] = d; m0[a[7:0]] = d; end
    @(posedge clk); #1;
    write_inst = 1'b0;
  endtask

  task automatic start2(input bit r, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.is_read = r;
    e.oor = is_oor(a);
    if (r) begin e.data = e.oor ? 16'h0000 : m2[a[7:0]]; last2 = e.data; end
    else begin e.data = last2; if (!e.oor) m2[a[7:0]] = d; end
    q2.push_back(e);
    bus2.req = 1'b1; bus2.rd = r; bus2.addr = a; bus2.din = d;
    @(posedge clk); #1;
    bus2.req = 1'b0;
  endtask

  task automatic wait2(output int cyc, output bit seen);
    seen = 1'b0; cyc = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (bus2.complete) begin seen = 1'b1; cyc = i; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus2.busy, bus2.complete, bus0.busy, bus0.complete} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 0000",
        {bus2.busy, bus2.complete, bus0.busy, bus0.complete});
    end
    n_checks++;
    if (bus2.dout !== 16'h0000 || bus0.dout !== 16'h0000) begin
      n_fail++; $display("FAIL reset_dout: got %h/%h, expected 0000", bus2.dout, bus0.dout);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    exp_t e;
    logic [1:0] exp_bc;
    preload(16'h0010, 16'h1234);
    start2(1'b1, 16'h0010, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      exp_bc = {c <= 3, c == 3};
      n_checks++;
      if ({bus2.busy, bus2.complete} !== exp_bc) begin
        n_fail++; $display("FAIL read_busy_complete cycle %0d: got %b, expected %b",
          c, {bus2.busy, bus2.complete}, exp_bc);
      end
      if (c == 3) begin
        e = q2.pop_front();
        n_checks++;
        if (bus2.dout !== e.data) begin
          n_fail++; $display("FAIL read_data: got %h, expected %h", bus2.dout, e.data);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (bus2.dout !== 16'h1234) begin
      n_fail++; $display("FAIL read_hold: got %h, expected 1234", bus2.dout);
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    int n, cyc;
    bit seen;
    e.is_read = 1'b0; e.oor = 1'b0; e.data = last2;
    m2[8'h20] = 16'hBEEF;
    q2.push_back(e);
    bus2.req = 1'b1; bus2.rd = 1'b0; bus2.addr = 16'h0020; bus2.din = 16'hBEEF;
    n = 0;
    // req stays high through WAIT and ACCESS edges; only one transaction may result
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 3) bus2.req = 1'b0;
      if (bus2.complete) begin
        n++;
        if (q2.size() > 0) begin
          e = q2.pop_front();
          n_checks++;
          if (bus2.dout !== e.data) begin
            n_fail++; $display("FAIL write_dout_hold: got %h, expected %h", bus2.dout, e.data);
          end
        end
      end
    end
    n_checks++;
    if (n != 1) begin
      n_fail++; $display("FAIL held_req_completes: got %0d, expected 1", n);
    end
    start2(1'b1, 16'h0020, 16'h0000);
    wait2(cyc, seen);
    e = q2.pop_front();
    n_checks++;
    if (!seen || cyc != 3 || bus2.dout !== e.data) begin
      n_fail++; $display("FAIL write_then_read: got %h at cycle %0d (seen %0b), expected %h at cycle 3",
        bus2.dout, cyc, seen, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    exp_t e;
    int cyc;
    bit seen;
    bit          rr[3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] aa[3] = '{16'h0105, 16'h0005, 16'h0105};
    logic [15:0] dd[3] = '{16'hAAAA, 16'h0000, 16'h0000};
    preload(16'h0005, 16'h0055);
    for (int k = 0; k < 3; k++) begin
      start2(rr[k], aa[k], dd[k]);
      wait2(cyc, seen);
      e = q2.pop_front();
      n_checks++;
      if (!seen || bus2.dout !== e.data) begin
        n_fail++; $display("FAIL wrap_%0d: got %h (seen %0b), expected %h", k, bus2.dout, seen, e.data);
      end
`ifdef LC3_MEM_RANGE_CHECK_EN
      n_checks++;
      if (err2 !== e.oor) begin
        n_fail++; $display("FAIL wrap_err_%0d: got %b, expected %b", k, err2, e.oor);
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    exp_t e;
    int cyc;
    bit seen;
    logic [15:0] ra[2] = '{16'h0007, 16'h0040};
    start2(1'b0, 16'h0007, 16'h1111);
    wait2(cyc, seen);
    e = q2.pop_front();
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL collide_write_timeout: got no complete, expected one"); end
    // Still inside the ACCESS cycle: the preload lands on the same edge as the CPU write.
    write_inst = 1'b1; addr_inst = 16'h0007; din_inst = 16'h2222;
    m2[8'h07] = 16'h2222; m0[8'h07] = 16'h2222;
    @(posedge clk); #1;
    write_inst = 1'b0;

    preload(16'h0040, 16'h0A0A);
    start2(1'b1, 16'h0040, 16'h0000);
    wait2(cyc, seen);
    e = q2.pop_front();
    write_inst = 1'b1; addr_inst = 16'h0040; din_inst = 16'h0B0B;
    m2[8'h40] = 16'h0B0B; m0[8'h40] = 16'h0B0B;
    n_checks++;
    if (!seen || bus2.dout !== e.data) begin
      n_fail++; $display("FAIL read_before_write: got %h (seen %0b), expected %h", bus2.dout, seen, e.data);
    end
    @(posedge clk); #1;
    write_inst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      start2(1'b1, ra[k], 16'h0000);
      wait2(cyc, seen);
      e = q2.pop_front();
      n_checks++;
      if (!seen || bus2.dout !== e.data) begin
        n_fail++; $display("FAIL collide_read_%0d: got %h (seen %0b), expected %h", k, bus2.dout, seen, e.data);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc, pulses;
    bit seen;
    preload(16'h0030, 16'h5555);
    bus2.req = 1'b1; bus2.rd = 1'b0; bus2.addr = 16'h0030; bus2.din = 16'h9999;
    @(posedge clk); #1;
    bus2.req = 1'b0;
    n_checks++;
    if (bus2.busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_started: busy %b, expected 1", bus2.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus2.busy, bus2.complete} !== 2'b00 || bus2.dout !== 16'h0000) begin
      n_fail++; $display("FAIL midreset_idle: busy/complete %b dout %h, expected 00 and 0000",
        {bus2.busy, bus2.complete}, bus2.dout);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus2.complete) pulses++;
      if (c == 1) begin @(posedge clk); #1; reset = 1'b1; end
    end
    last2 = 16'h0000; last0 = 16'h0000;
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL midreset_complete: got %0d pulses, expected 0", pulses);
    end
    @(posedge clk); #1;
    start2(1'b1, 16'h0030, 16'h0000);
    wait2(cyc, seen);
    e = q2.pop_front();
    n_checks++;
    if (!seen || bus2.dout !== e.data) begin
      n_fail++; $display("FAIL midreset_mem: got %h (seen %0b), expected %h", bus2.dout, seen, e.data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency0();
    exp_t e;
    bit drive;
    int k;
    bit          rr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] aa[4] = '{16'h0050, 16'h0052, 16'h0052, 16'h0051};
    logic [15:0] dd[4] = '{16'h0000, 16'h1357, 16'h0000, 16'h0000};
    preload(16'h0050, 16'h0F0F);
    preload(16'h0051, 16'hF0F0);
    for (int c = 0; c < 9; c++) begin
      drive = (c % 2 == 0) && (c < 8);
      if (drive) begin
        k = c / 2;
        e.is_read = rr[k]; e.oor = 1'b0;
        if (rr[k]) begin e.data = m0[aa[k][7:0]]; last0 = e.data; end
        else begin e.data = last0; m0[aa[k][7:0]] = dd[k]; end
        q0.push_back(e);
        bus0.req = 1'b1; bus0.rd = rr[k]; bus0.addr = aa[k]; bus0.din = dd[k];
      end else begin
        bus0.req = 1'b0;
      end
      @(posedge clk); #1;
      n_checks++;
      if ({bus0.busy, bus0.complete} !== {drive, drive}) begin
        n_fail++; $display("FAIL lat0_complete cycle %0d: got %b, expected %b",
          c + 1, {bus0.busy, bus0.complete}, {drive, drive});
      end
      if (drive) begin
        e = q0.pop_front();
        n_checks++;
        if (bus0.dout !== e.data) begin
          n_fail++; $display("FAIL lat0_data cycle %0d: got %h, expected %h", c + 1, bus0.dout, e.data);
        end
      end
    end
    bus0.req = 1'b0;
  endtask

  initial begin
    bus2.req = 1'b0; bus2.rd = 1'b0; bus2.addr = '0; bus2.din = '0;
    bus0.req = 1'b0; bus0.rd = 1'b0; bus0.addr = '0; bus0.din = '0;
    #2;
    test_reset();
    test_read();
    test_write_read();
    test_wrap();
    test_collision();
    test_reset_mid();
    test_latency0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
